// File: rtl/rotate_left_seq_if.sv
// Handshake and data bundle between the ALU sequencer and the multi-cycle rotate-left unit.
interface rotate_left_seq_if;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned CNT_W  = 5;

    logic              start;
    logic [DATA_W-1:0] value;
    logic [CNT_W-1:0]  count;
    logic              busy;
    logic              done;
    logic [DATA_W-1:0] result;

    modport master (output start, output value, output count,
                    input  busy,  input  done,  input  result);
    modport slave  (input  start, input  value, input  count,
                    output busy,  output done,  output result);
endinterface

// File: rtl/rotate_left_seq.sv
// Multi-cycle 32-bit rotate-left: rotates by up to STEP bits per clock under a start/busy/done handshake.
module rotate_left_seq #(
    parameter int unsigned STEP = 1
) (
    input  logic              clk,
    input  logic              clr,
    rotate_left_seq_if.slave  bus
);
    localparam int unsigned DATA_W = 32;
    localparam int unsigned CNT_W  = 5;
    localparam logic [CNT_W-1:0] STEP_W = CNT_W'(STEP);

    if (!(STEP == 1 || STEP == 2 || STEP == 4 || STEP == 8)) begin : g_bad_step
        $error("rotate_left_seq: STEP must be 1, 2, 4 or 8");
    end

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [DATA_W-1:0]  work_q,   work_d;
    logic [CNT_W-1:0]   rem_q,    rem_d;
    logic [DATA_W-1:0]  result_q, result_d;
    logic               busy_q,   busy_d;
    logic               done_q,   done_d;

    logic [CNT_W-1:0]   step_k;
    logic [CNT_W-1:0]   rem_next;
    logic [DATA_W-1:0]  work_rot;

    function automatic logic [DATA_W-1:0] rotl(input logic [DATA_W-1:0] x,
                                                input logic [CNT_W-1:0]  k);
        logic [CNT_W:0] back;
        back = (CNT_W+1)'(DATA_W) - {1'b0, k};
        // A zero amount yields x >> 32 == 0, so the OR collapses to x.
        return (x << k) | (x >> back);
    endfunction

    // Final partial step rotates by the remainder only.
    always_comb begin
        step_k   = (rem_q < STEP_W) ? rem_q : STEP_W;
        rem_next = rem_q - step_k;
        work_rot = rotl(work_q, step_k);
    end

    always_comb begin
        state_d  = state_q;
        work_d   = work_q;
        rem_d    = rem_q;
        result_d = result_q;
        busy_d   = 1'b0;
        done_d   = 1'b0;

        unique case (state_q)
            IDLE, DONE: begin
                state_d = IDLE;
                if (bus.start) begin
                    work_d = bus.value;
                    rem_d  = bus.count;
                    if (bus.count == '0) begin
                        state_d  = DONE;
                        result_d = bus.value;
                        done_d   = 1'b1;
                    end else begin
                        state_d = RUN;
                        busy_d  = 1'b1;
                    end
                end
            end
            RUN: begin
                work_d = work_rot;
                rem_d  = rem_next;
                if (rem_next == '0) begin
                    state_d  = DONE;
                    result_d = work_rot;
                    done_d   = 1'b1;
                end else begin
                    busy_d = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            state_q  <= IDLE;
            work_q   <= '0;
            rem_q    <= '0;
            result_q <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            work_q   <= work_d;
            rem_q    <= rem_d;
            result_q <= result_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign bus.busy   = busy_q;
    assign bus.done   = done_q;
    assign bus.result = result_q;
endmodule

// File: tb/tb_rotate_left_seq.sv
// Bench for rotate_left_seq: three instances (STEP 1, 4, 8) checked against vectors and a rotate model.
module tb_rotate_left_seq;
    logic clk;
    logic clr;

    logic        start_r  [3];
    logic [31:0] value_r  [3];
    logic [4:0]  count_r  [3];
    logic        busy_w   [3];
    logic        done_w   [3];
    logic [31:0] result_w [3];

    int steps [3] = '{1, 4, 8};
    int done_cnt [3] = '{0, 0, 0};

    int checks = 0;
    int errors = 0;

    rotate_left_seq_if if0 ();
    rotate_left_seq_if if1 ();
    rotate_left_seq_if if2 ();

    rotate_left_seq #(.STEP(1)) u_s1 (.clk(clk), .clr(clr), .bus(if0));
    rotate_left_seq #(.STEP(4)) u_s4 (.clk(clk), .clr(clr), .bus(if1));
    rotate_left_seq #(.STEP(8)) u_s8 (.clk(clk), .clr(clr), .bus(if2));

    assign if0.start = start_r[0];
    assign if0.value = value_r[0];
    assign if0.count = count_r[0];
    assign if1.start = start_r[1];
    assign if1.value = value_r[1];
    assign if1.count = count_r[1];
    assign if2.start = start_r[2];
    assign if2.value = value_r[2];
    assign if2.count = count_r[2];
    assign busy_w[0] = if0.busy;
    assign busy_w[1] = if1.busy;
    assign busy_w[2] = if2.busy;
    assign done_w[0] = if0.done;
    assign done_w[1] = if1.done;
    assign done_w[2] = if2.done;
    assign result_w[0] = if0.result;
    assign result_w[1] = if1.result;
    assign result_w[2] = if2.result;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count done pulses and watch for busy/done overlap on every edge.
    always @(posedge clk) begin
        for (int d = 0; d < 3; d++) begin
            if (done_w[d]) done_cnt[d] <= done_cnt[d] + 1;
            checks <= checks + 1;
            if (busy_w[d] && done_w[d]) begin
                errors <= errors + 1;
                $display("FAIL busy_done_overlap dut%0d: got busy=1 done=1, want not both", d);
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
        end
    endtask

    // Reference rotate: take the window of a doubled word.
    function automatic logic [31:0] model_rotl(input logic [31:0] x, input int n);
        logic [63:0] dbl;
        dbl = {x, x} >> (32 - n);
        return dbl[31:0];
    endfunction

    // Busy cycles implied by the FSM: one RUN cycle per STEP-sized chunk of the amount.
    function automatic int model_busy(input int d, input int c);
        return (c + steps[d] - 1) / steps[d];
    endfunction

    // Pulse start for one cycle, scramble operands, then wait (bounded) for done.
    task automatic run_op(input int d, input logic [31:0] v, input logic [4:0] c,
                          output logic [31:0] res, output int nbusy, output int nedge,
                          output bit ok);
        @(negedge clk);
        start_r[d] = 1'b1;
        value_r[d] = v;
        count_r[d] = c;
        @(negedge clk);
        start_r[d] = 1'b0;
        value_r[d] = $urandom;
        count_r[d] = 5'($urandom);
        nedge = 1;
        nbusy = 0;
        while (!done_w[d] && nedge < 100) begin
            if (busy_w[d]) nbusy++;
            @(negedge clk);
            nedge++;
        end
        ok  = done_w[d];
        res = result_w[d];
    endtask

    task automatic check_op(input string tag, input int d, input logic [31:0] v,
                            input logic [4:0] c, input logic [31:0] exp_r, input int exp_b);
        logic [31:0] res;
        int nbusy, nedge, cnt0;
        bit ok;
        cnt0 = done_cnt[d];
        run_op(d, v, c, res, nbusy, nedge, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s_timeout dut%0d: no done within 100 cycles", tag, d);
        end
        chk({tag, "_result"}, res, exp_r);
        chk({tag, "_busy_cycles"}, 32'(nbusy), 32'(exp_b));
        chk({tag, "_latency"}, 32'(nedge), 32'(exp_b + 1));
        @(negedge clk);
        chk({tag, "_done_low_after"}, 32'(done_w[d]), 32'd0);
        chk({tag, "_pulses"}, 32'(done_cnt[d] - cnt0), 32'd1);
        chk({tag, "_held"}, result_w[d], exp_r);
    endtask

    typedef struct {
        string       tag;
        int          d;
        logic [31:0] v;
        logic [4:0]  c;
        logic [31:0] r;
        int          nb;
    } vec_t;

    initial begin : main
        vec_t vecs[$];
        logic [31:0] res;
        int nbusy, nedge, cnt0, seen;
        bit ok;

        vecs.push_back('{"wrap_s1",     0, 32'h80000001, 5'd1,  32'h00000003, 1});
        vecs.push_back('{"nibble_s1",   0, 32'h12345678, 5'd4,  32'h23456781, 4});
        vecs.push_back('{"nibble_s4",   1, 32'h12345678, 5'd4,  32'h23456781, 1});
        vecs.push_back('{"zero_s1",     0, 32'hDEADBEEF, 5'd0,  32'hDEADBEEF, 0});
        vecs.push_back('{"zero_s8",     2, 32'hDEADBEEF, 5'd0,  32'hDEADBEEF, 0});
        vecs.push_back('{"max_s1",      0, 32'h00000001, 5'd31, 32'h80000000, 31});
        vecs.push_back('{"max_s4",      1, 32'h00000001, 5'd31, 32'h80000000, 8});
        vecs.push_back('{"max_s8",      2, 32'h00000001, 5'd31, 32'h80000000, 4});
        vecs.push_back('{"partial_s8",  2, 32'h0000FFFF, 5'd13, 32'h1FFFE000, 2});
        vecs.push_back('{"byte_s8",     2, 32'hA5000000, 5'd8,  32'h000000A5, 1});

        for (int d = 0; d < 3; d++) begin
            start_r[d] = 1'b0;
            value_r[d] = '0;
            count_r[d] = '0;
        end
        clr = 1'b1;
        repeat (2) @(negedge clk);
        for (int d = 0; d < 3; d++) begin
            chk("reset_busy", 32'(busy_w[d]), 32'd0);
            chk("reset_done", 32'(done_w[d]), 32'd0);
            chk("reset_result", result_w[d], 32'd0);
        end
        clr = 1'b0;

        foreach (vecs[i])
            check_op(vecs[i].tag, vecs[i].d, vecs[i].v, vecs[i].c, vecs[i].r, vecs[i].nb);

        // Start pulse while busy is dropped; start during DONE is taken back-to-back.
        cnt0 = done_cnt[0];
        @(negedge clk);
        start_r[0] = 1'b1; value_r[0] = 32'h0000000F; count_r[0] = 5'd8;
        @(negedge clk);
        start_r[0] = 1'b1; value_r[0] = 32'hFFFFFFFF; count_r[0] = 5'd5;
        @(negedge clk);
        start_r[0] = 1'b0; value_r[0] = 32'hAAAAAAAA; count_r[0] = 5'd3;
        seen = 0;
        while (!done_w[0] && seen < 100) begin
            @(negedge clk);
            seen++;
        end
        chk("hs_first_done", 32'(done_w[0]), 32'd1);
        chk("hs_first_result", result_w[0], 32'h00000F00);
        chk("hs_first_latency", 32'(seen + 2), 32'd9);
        start_r[0] = 1'b1; value_r[0] = 32'h00000001; count_r[0] = 5'd2;
        @(negedge clk);
        start_r[0] = 1'b0; value_r[0] = 32'h0; count_r[0] = 5'd0;
        chk("hs_b2b_busy", 32'(busy_w[0]), 32'd1);
        seen = 0;
        while (!done_w[0] && seen < 100) begin
            @(negedge clk);
            seen++;
        end
        chk("hs_second_result", result_w[0], 32'h00000004);
        repeat (3) @(negedge clk);
        chk("hs_pulses", 32'(done_cnt[0] - cnt0), 32'd2);
        chk("hs_idle_busy", 32'(busy_w[0]), 32'd0);

        // Clear in the middle of a 20-step rotation discards it.
        cnt0 = done_cnt[0];
        @(negedge clk);
        start_r[0] = 1'b1; value_r[0] = 32'h00000001; count_r[0] = 5'd20;
        @(negedge clk);
        start_r[0] = 1'b0;
        repeat (4) @(negedge clk);
        chk("clr_was_busy", 32'(busy_w[0]), 32'd1);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        chk("clr_busy", 32'(busy_w[0]), 32'd0);
        chk("clr_done", 32'(done_w[0]), 32'd0);
        chk("clr_result", result_w[0], 32'd0);
        chk("clr_result_s8", result_w[2], 32'd0);
        repeat (30) @(negedge clk);
        chk("clr_no_pulse", 32'(done_cnt[0] - cnt0), 32'd0);
        chk("clr_stays_idle", 32'(busy_w[0]), 32'd0);
        check_op("after_clr", 0, 32'h00000001, 5'd1, 32'h00000002, 1);

        // Random operations against the rotate model.
        for (int n = 0; n < 60; n++) begin
            int d;
            logic [31:0] v;
            logic [4:0] c;
            d = int'($urandom_range(0, 2));
            v = $urandom;
            c = 5'($urandom_range(0, 31));
            check_op("rand", d, v, c, model_rotl(v, int'(c)), model_busy(d, int'(c)));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end
endmodule
